pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It generates the enables and bubble/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses through a req/ready handshake. It sits beside the datapath and drives the en/flush inputs of the stage registers.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on dmem_ready before raising mem_err
BR_FLUSH_CYC, 1, cycles of IF/ID + ID/EX flush after a taken branch (1..3)
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
IFID_Rn  input  5  source reg A of instruction in ID
IFID_Rm  input  5  source reg B of instruction in ID
IFID_uses_Rm  input  1  ID instruction reads Rm (0 for immediates)
IDEX_Mem2Reg  input  1  EX instruction is a load
IDEX_Rd  input  5  dest reg of EX instruction
br_taken  input  1  branch resolved taken in EX this cycle
EXMEM_MemWrite  input  1  MEM-stage instruction is a store
EXMEM_Mem2Reg  input  1  MEM-stage instruction is a load
dmem_ready  input  1  data memory completes the current access
pc_en  output  1  PC register enable
ifid_en  output  1  IF/ID enable
ifid_flush  output  1  IF/ID loads NOP
idex_bubble  output  1  ID/EX loads zeroed control (bubble)
exmem_en  output  1  EX/MEM enable
memwb_bubble  output  1  MEM/WB loads zeroed control
dmem_req  output  1  data memory access request
mem_err  output  1  sticky: memory timeout occurred
state  output  2  current FSM state (debug)

Behaviour:
- All outputs are registered or decoded from registered state plus current inputs. On reset_n low: state=RUN, counters=0, mem_err=0. Outputs while in reset: pc_en=ifid_en=exmem_en=1, all flush/bubble/req=0.
- States: RUN=0, MEM_WAIT=1, BR_FLUSH=2, HALT=3.
- load-use hazard: IDEX_Mem2Reg & IDEX_Rd!=31 & (IDEX_Rd==IFID_Rn | (IFID_uses_Rm & IDEX_Rd==IFID_Rm)).
- mem_op = EXMEM_MemWrite | EXMEM_Mem2Reg.
- Priority, highest first: MEM_WAIT stall > br_taken flush > load-use stall.
- RUN:
  - mem_op & !dmem_ready: dmem_req=1, pc_en=ifid_en=exmem_en=0, memwb_bubble=1, idex_bubble=0. ID/EX is held implicitly because all upstream stages are frozen. Next state MEM_WAIT, wait counter cleared.
  - mem_op & dmem_ready: dmem_req=1, single-cycle completion, no stall.
  - br_taken: ifid_flush=1, idex_bubble=1, pc_en=1. If BR_FLUSH_CYC>1, go to BR_FLUSH with a counter loaded to BR_FLUSH_CYC-1.
  - load-use: pc_en=ifid_en=0, idex_bubble=1, exactly one cycle. Re-evaluated next cycle; the hazard clears because the load has advanced.
- MEM_WAIT: dmem_req=1, all stage enables 0, memwb_bubble=1.
  - dmem_ready=1: enables restored that same cycle, memwb_bubble=0, next state RUN.
  - Wait counter reaches MEM_TIMEOUT-1 without ready: mem_err set (sticky until reset), next state HALT.
  - br_taken and load-use are ignored while in MEM_WAIT; the EX stage is frozen, so both are re-presented afterwards.
- BR_FLUSH: ifid_flush=idex_bubble=1 each cycle; counter decrements; at 0 go to RUN. A mem_op stall arriving here takes priority: go to MEM_WAIT and drop the remaining flush count. This is safe because the branch target has already been fetched.
- HALT: all enables 0, dmem_req=0, bubbles 0. Only reset exits.
- Asynchronous reset mid-MEM_WAIT aborts the access: dmem_req drops immediately.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles, flush_cycles and memwait_cycles, each CNT_W wide, saturating at all-ones.
  - stall_cycles increments on each load-use stall cycle.
  - flush_cycles increments on each cycle with ifid_flush=1.
  - memwait_cycles increments on each MEM_WAIT cycle.
  - All cleared by reset.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Load-use: IDEX_Mem2Reg=1, IDEX_Rd=5, IFID_Rn=5 -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_bubble=1, then pc_en=1. Repeat with IDEX_Rd=31 -> no stall.
- Rm gating: IDEX_Rd=7, IFID_Rm=7, IFID_uses_Rm=0 -> no stall; with IFID_uses_Rm=1 -> 1 stall cycle.
- Multi-cycle load: EXMEM_Mem2Reg=1, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, state=MEM_WAIT for 3 cycles, exmem_en=0 for 3 cycles, RUN on the 4th.
- Branch: br_taken=1 with BR_FLUSH_CYC=2 -> ifid_flush=idex_bubble=1 for 2 cycles, state 2 for 1 cycle. br_taken coincident with a load-use hazard -> flush only, no stall.
- Timeout: EXMEM_MemWrite=1, dmem_ready held 0 -> mem_err=1 after 16 cycles, state=HALT, pc_en=0 until reset_n pulse; after reset state=RUN, mem_err=0.
- Reset mid-wait: assert reset_n=0 in MEM_WAIT -> dmem_req=0 asynchronously. With HAZARD_PERF_CNT_EN, memwait_cycles=0 after reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
// Optional saturating performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int BR_FLUSH_CYC = 1,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] IFID_Rn,
    input  logic [4:0] IFID_Rm,
    input  logic       IFID_uses_Rm,
    input  logic       IDEX_Mem2Reg,
    input  logic [4:0] IDEX_Rd,
    input  logic       br_taken,
    input  logic       EXMEM_MemWrite,
    input  logic       EXMEM_Mem2Reg,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_en,
    output logic       memwb_bubble,
    output logic       dmem_req,
    output logic       mem_err,
    output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [CNT_W-1:0] memwait_cycles
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_BR_FLUSH = 2'd2,
        S_HALT     = 2'd3
    } state_e;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic load_use;
    logic mem_op;
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c;
    logic exmem_en_c, memwb_bubble_c, dmem_req_c;

    assign load_use = IDEX_Mem2Reg && (IDEX_Rd != 5'd31) &&
                      ((IDEX_Rd == IFID_Rn) || (IFID_uses_Rm && (IDEX_Rd == IFID_Rm)));
    assign mem_op   = EXMEM_MemWrite || EXMEM_Mem2Reg;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        mem_err_d      = mem_err_q;
        pc_en_c        = 1'b1;
        ifid_en_c      = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        exmem_en_c     = 1'b1;
        memwb_bubble_c = 1'b0;
        dmem_req_c     = 1'b0;
        case (state_q)
            S_RUN, S_BR_FLUSH: begin
                if (mem_op && !dmem_ready) begin
                    // A memory stall pre-empts any pending flush; the branch target is already fetched.
                    dmem_req_c     = 1'b1;
                    pc_en_c        = 1'b0;
                    ifid_en_c      = 1'b0;
                    exmem_en_c     = 1'b0;
                    memwb_bubble_c = 1'b1;
                    state_d        = S_MEM_WAIT;
                    wait_cnt_d     = '0;
                end else begin
                    dmem_req_c = mem_op;
                    if (state_q == S_BR_FLUSH) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        flush_cnt_d   = flush_cnt_q - 2'd1;
                        if (flush_cnt_q <= 2'd1) begin
                            state_d = S_RUN;
                        end
                    end else if (br_taken) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        if (BR_FLUSH_CYC > 1) begin
                            state_d     = S_BR_FLUSH;
                            flush_cnt_d = 2'(BR_FLUSH_CYC - 1);
                        end
                    end else if (load_use) begin
                        pc_en_c       = 1'b0;
                        ifid_en_c     = 1'b0;
                        idex_bubble_c = 1'b1;
                    end
                end
            end
            S_MEM_WAIT: begin
                dmem_req_c = 1'b1;
                if (dmem_ready) begin
                    state_d = S_RUN;
                end else begin
                    pc_en_c        = 1'b0;
                    ifid_en_c      = 1'b0;
                    exmem_en_c     = 1'b0;
                    memwb_bubble_c = 1'b1;
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        mem_err_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            default: begin
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                exmem_en_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Reset forces the free-running defaults so a held reset also drops dmem_req at once.
    assign pc_en        = !reset_n || pc_en_c;
    assign ifid_en      = !reset_n || ifid_en_c;
    assign exmem_en     = !reset_n || exmem_en_c;
    assign ifid_flush   = reset_n && ifid_flush_c;
    assign idex_bubble  = reset_n && idex_bubble_c;
    assign memwb_bubble = reset_n && memwb_bubble_c;
    assign dmem_req     = reset_n && dmem_req_c;
    assign mem_err      = mem_err_q;
    assign state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_pc_q, flush_pc_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    // A bubble without a flush only happens on a load-use stall.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_pc_d    = flush_pc_q;
        memwait_cnt_d = memwait_cnt_q;
        if (idex_bubble_c && !ifid_flush_c && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_c && !(&flush_pc_q)) begin
            flush_pc_d = flush_pc_q + CNT_W'(1);
        end
        if ((state_q == S_MEM_WAIT) && !(&memwait_cnt_q)) begin
            memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q   <= '0;
            flush_pc_q    <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_pc_q    <= flush_pc_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign stall_cycles   = stall_cnt_q;
    assign flush_cycles   = flush_pc_q;
    assign memwait_cycles = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT  = 16;
    localparam int BR_FLUSH_CYC = 2;
    localparam int CNT_W        = 4;
    localparam int MAXC         = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] rn;
        logic [4:0] rm;
        logic       um;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       mw;
        logic       ml;
        logic       rdy;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] IFID_Rn, IFID_Rm, IDEX_Rd;
    logic       IFID_uses_Rm, IDEX_Mem2Reg, br_taken;
    logic       EXMEM_MemWrite, EXMEM_Mem2Reg, dmem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble;
    logic       exmem_en, memwb_bubble, dmem_req, mem_err;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_cycles, memwait_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Model: pipeline mode (0 run, 1 waiting on memory, 2 extra flush, 3 halted)
    int m_mode;
    int m_waited;
    int m_left;
    bit m_err;
    int m_stall, m_flush, m_memwait;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .BR_FLUSH_CYC(BR_FLUSH_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .IFID_Rn       (IFID_Rn),
        .IFID_Rm       (IFID_Rm),
        .IFID_uses_Rm  (IFID_uses_Rm),
        .IDEX_Mem2Reg  (IDEX_Mem2Reg),
        .IDEX_Rd       (IDEX_Rd),
        .br_taken      (br_taken),
        .EXMEM_MemWrite(EXMEM_MemWrite),
        .EXMEM_Mem2Reg (EXMEM_Mem2Reg),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .exmem_en      (exmem_en),
        .memwb_bubble  (memwb_bubble),
        .dmem_req      (dmem_req),
        .mem_err       (mem_err),
        .state         (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_cycles  (flush_cycles),
        .memwait_cycles(memwait_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic stim_t mk(int rn, int rm, int um, int ld, int rd, int br, int mw, int ml, int rdy);
        stim_t s;
        s.rn = 5'(rn); s.rm = 5'(rm); s.um = 1'(um); s.ld = 1'(ld); s.rd = 5'(rd);
        s.br = 1'(br); s.mw = 1'(mw); s.ml = 1'(ml); s.rdy = 1'(rdy);
        return s;
    endfunction

    function automatic int sat(int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    function automatic logic [9:0] dut_out();
        return {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, dmem_req, mem_err, state};
    endfunction

    function automatic bit hazard_now();
        return IDEX_Mem2Reg && (IDEX_Rd != 5'd31) &&
               ((IDEX_Rd == IFID_Rn) || (IFID_uses_Rm && (IDEX_Rd == IFID_Rm)));
    endfunction

    // Expected outputs: {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, dmem_req, mem_err, state}
    function automatic logic [9:0] model_out();
        bit memop, flush, stall;
        logic [7:0] o;
        memop = EXMEM_MemWrite || EXMEM_Mem2Reg;
        if (!reset_n) return {8'b1100_1000, 2'd0};
        if (m_mode == 3) begin
            o = {7'b0, m_err};
        end else if (m_mode == 1) begin
            o = dmem_ready ? {7'b1100_101, m_err} : {7'b0000_011, m_err};
        end else if (memop && !dmem_ready) begin
            o = {7'b0000_011, m_err};
        end else begin
            flush = (m_mode == 2) || br_taken;
            stall = !flush && hazard_now();
            o = {!stall, !stall, flush, flush || stall, 1'b1, 1'b0, memop, m_err};
        end
        return {o, 2'(m_mode)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_left = 0; m_err = 0;
        m_stall = 0; m_flush = 0; m_memwait = 0;
    endtask

    task automatic model_clock();
        bit memstall;
        memstall = (EXMEM_MemWrite || EXMEM_Mem2Reg) && !dmem_ready;
        if (!reset_n) return;
        if (m_mode == 1) m_memwait = sat(m_memwait);
        if (!memstall && ((m_mode == 0 && br_taken) || m_mode == 2)) m_flush = sat(m_flush);
        if (!memstall && m_mode == 0 && !br_taken && hazard_now()) m_stall = sat(m_stall);
        case (m_mode)
            0, 2: begin
                if (memstall) begin
                    m_mode = 1; m_waited = 0;
                end else if (m_mode == 2) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = 0;
                end else if (br_taken && BR_FLUSH_CYC > 1) begin
                    m_mode = 2; m_left = BR_FLUSH_CYC - 1;
                end
            end
            1: begin
                if (dmem_ready) m_mode = 0;
                else if (m_waited == MEM_TIMEOUT - 1) begin m_mode = 3; m_err = 1; end
                else m_waited = m_waited + 1;
            end
            default: ;
        endcase
    endtask

    task automatic drive(input stim_t s);
        IFID_Rn = s.rn; IFID_Rm = s.rm; IFID_uses_Rm = s.um; IDEX_Mem2Reg = s.ld; IDEX_Rd = s.rd;
        br_taken = s.br; EXMEM_MemWrite = s.mw; EXMEM_Mem2Reg = s.ml; dmem_ready = s.rdy;
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        drive(s);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        drive(mk(5, 5, 1, 1, 5, 1, 1, 1, 0));
        #1;
        for (int i = 0; i < 2; i++) begin
            if (dut_out() !== 10'b1100_1000_00) begin
                $display("FAIL reset_outputs cyc %0d got %b exp %b", i, dut_out(), 10'b1100_1000_00);
                errors++;
            end
            checks++;
            @(negedge clk);
            #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        if ({stall_cycles, flush_cycles, memwait_cycles} !== '0) begin
            $display("FAIL reset_perf got %0d/%0d/%0d exp 0/0/0", stall_cycles, flush_cycles, memwait_cycles);
            errors++;
        end
        checks++;
`endif
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t seq[6];
        int stalls = 0;
        seq[0] = mk(5, 0, 0, 1, 5, 0, 0, 0, 1);
        seq[1] = mk(5, 0, 0, 0, 0, 0, 0, 0, 1);
        seq[2] = mk(31, 0, 0, 1, 31, 0, 0, 0, 1);
        seq[3] = mk(1, 7, 0, 1, 7, 0, 0, 0, 1);
        seq[4] = mk(1, 7, 1, 1, 7, 0, 0, 0, 1);
        seq[5] = mk(1, 7, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            apply(seq[i]);
            if (dut_out() !== model_out()) begin
                $display("FAIL load_use cyc %0d got %b exp %b", i, dut_out(), model_out());
                errors++;
            end
            checks++;
            if (!pc_en) stalls++;
            model_clock();
        end
        if (stalls !== 2) begin
            $display("FAIL load_use_stall_count got %0d exp 2", stalls);
            errors++;
        end
        checks++;
    endtask

    task automatic test_multicycle_load();
        int req_n = 0, wait_n = 0, hold_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            else if (i == 3) apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
            else apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
            if (dut_out() !== model_out()) begin
                $display("FAIL mc_load cyc %0d got %b exp %b", i, dut_out(), model_out());
                errors++;
            end
            checks++;
            if (dmem_req) req_n++;
            if (state == 2'd1) wait_n++;
            if (!exmem_en) hold_n++;
            model_clock();
        end
        if (req_n !== 4 || wait_n !== 3 || hold_n !== 3) begin
            $display("FAIL mc_load_counts got req=%0d wait=%0d hold=%0d exp 4/3/3", req_n, wait_n, hold_n);
            errors++;
        end
        checks++;
    endtask

    task automatic test_branch();
        stim_t seq[9];
        int flush_n = 0, brst_n = 0;
        seq[0] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        seq[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        seq[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        seq[3] = mk(3, 0, 0, 1, 3, 1, 0, 0, 1);
        seq[4] = mk(3, 0, 0, 1, 3, 0, 0, 0, 1);
        seq[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        seq[6] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
        seq[7] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        seq[8] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 9; i++) begin
            apply(seq[i]);
            if (dut_out() !== model_out()) begin
                $display("FAIL branch cyc %0d got %b exp %b", i, dut_out(), model_out());
                errors++;
            end
            checks++;
            if (i < 3 && ifid_flush && idex_bubble) flush_n++;
            if (i < 3 && state == 2'd2) brst_n++;
            model_clock();
        end
        if (flush_n !== 2 || brst_n !== 1) begin
            $display("FAIL branch_counts got flush=%0d brstate=%0d exp 2/1", flush_n, brst_n);
            errors++;
        end
        checks++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < MEM_TIMEOUT + 5; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 1, 0, (i >= MEM_TIMEOUT + 2) ? 1 : 0));
            if (dut_out() !== model_out()) begin
                $display("FAIL timeout cyc %0d got %b exp %b", i, dut_out(), model_out());
                errors++;
            end
            checks++;
            model_clock();
        end
        if (mem_err !== 1'b1 || state !== 2'd3 || pc_en !== 1'b0) begin
            $display("FAIL timeout_halt got err=%b st=%0d pc=%b exp 1/3/0", mem_err, state, pc_en);
            errors++;
        end
        checks++;
        do_reset();
        #1;
        if (mem_err !== 1'b0 || state !== 2'd0 || pc_en !== 1'b1) begin
            $display("FAIL timeout_clear got err=%b st=%0d pc=%b exp 0/0/1", mem_err, state, pc_en);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 2; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            if (dut_out() !== model_out()) begin
                $display("FAIL mid_wait cyc %0d got %b exp %b", i, dut_out(), model_out());
                errors++;
            end
            checks++;
            model_clock();
        end
        @(posedge clk);
        #2;
        if (state !== 2'd1 || dmem_req !== 1'b1) begin
            $display("FAIL mid_wait_pre got st=%0d req=%b exp 1/1", state, dmem_req);
            errors++;
        end
        checks++;
        reset_n = 1'b0;
        model_reset();
        #1;
        if (dmem_req !== 1'b0 || state !== 2'd0 || pc_en !== 1'b1) begin
            $display("FAIL mid_wait_async got req=%b st=%0d pc=%b exp 0/0/1", dmem_req, state, pc_en);
            errors++;
        end
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if (memwait_cycles !== '0) begin
            $display("FAIL mid_wait_perf got %0d exp 0", memwait_cycles);
            errors++;
        end
        checks++;
`endif
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        stim_t s;
        int regs[5] = '{0, 1, 2, 3, 31};
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 3) do_reset();
            s = mk(regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], $urandom_range(0, 1),
                   ($urandom_range(0, 2) == 0) ? 1 : 0, regs[$urandom_range(0, 4)],
                   ($urandom_range(0, 5) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
                   ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
            apply(s);
            if (dut_out() !== model_out()) begin
                $display("FAIL random cyc %0d got %b exp %b", i, dut_out(), model_out());
                errors++;
            end
            checks++;
`ifdef HAZARD_PERF_CNT_EN
            if (stall_cycles !== CNT_W'(m_stall) || flush_cycles !== CNT_W'(m_flush) ||
                memwait_cycles !== CNT_W'(m_memwait)) begin
                $display("FAIL random_perf cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                         stall_cycles, flush_cycles, memwait_cycles, m_stall, m_flush, m_memwait);
                errors++;
            end
            checks++;
`endif
            model_clock();
        end
    endtask

    initial begin
        reset_n = 1'b1;
        model_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        test_reset();
        test_load_use();
        test_multicycle_load();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
